seq_alu_datapath: RTL and testbench



---
 rtl/seq_alu_pkg.sv | 17 +
 rtl/seq_alu_if.sv | 33 +++
 rtl/regfile_zr.sv | 44 ++++
 rtl/seq_alu_datapath.sv | 144 ++++++++++++++
 tb/tb_seq_alu_datapath.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/seq_alu_pkg.sv
// Shared op-codes and sequencer state encoding for the sequential ALU datapath.
package seq_alu_pkg;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_EXEC = 2'd2,
        S_WB   = 2'd3
    } state_t;

endpackage

// File: rtl/seq_alu_if.sv
// Instruction, result and debug-read bundle between the board decode logic and the datapath.
interface seq_alu_if #(
    parameter int N    = 8,
    parameter int NREG = 8
);
    localparam int AW = $clog2(NREG);

    logic          in_valid;
    logic          in_ready;
    logic [2:0]    op;
    logic [AW-1:0] ra1;
    logic [AW-1:0] ra2;
    logic [AW-1:0] wa3;
    logic          use_imm;
    logic [N-1:0]  imm;
    logic          out_valid;
    logic [N-1:0]  result;
    logic          zero;
    logic          busy;
    logic [AW-1:0] dbg_addr;
    logic [N-1:0]  dbg_data;

    modport master (
        output in_valid, op, ra1, ra2, wa3, use_imm, imm, dbg_addr,
        input  in_ready, out_valid, result, zero, busy, dbg_data
    );

    modport slave (
        input  in_valid, op, ra1, ra2, wa3, use_imm, imm, dbg_addr,
        output in_ready, out_valid, result, zero, busy, dbg_data
    );

endinterface

// File: rtl/regfile_zr.sv
// Register file with R0 tied to zero: two combinational read ports, one debug read, one write.
// Write lands on the rising edge with we high; async active-low clear of every entry.
module regfile_zr #(
    parameter int N    = 8,
    parameter int NREG = 8,
    parameter int AW   = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] wa,
    input  logic [N-1:0]  wd,
    input  logic [AW-1:0] ra1,
    output logic [N-1:0]  rd1,
    input  logic [AW-1:0] ra2,
    output logic [N-1:0]  rd2,
    input  logic [AW-1:0] dbg_addr,
    output logic [N-1:0]  dbg_data
);

    logic [N-1:0] mem_q [NREG];
    logic [N-1:0] mem_d [NREG];

    always_comb begin
        mem_d = mem_q;
        if (we && (wa != '0)) begin
            mem_d[wa] = wd;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_q <= '{default: '0};
        end else begin
            mem_q <= mem_d;
        end
    end

    // Entry 0 is never written, but the read mux forces zero so it cannot leak a stale value.
    assign rd1      = (ra1      == '0) ? '0 : mem_q[ra1];
    assign rd2      = (ra2      == '0) ? '0 : mem_q[ra2];
    assign dbg_data = (dbg_addr == '0) ? '0 : mem_q[dbg_addr];

endmodule

// File: rtl/seq_alu_datapath.sv
// Self-sequencing regfile/ALU: IDLE->READ->EXEC->WB, accept to writeback in 3 edges, one instr per 4 cycles.
// in_ready only in IDLE; in_valid ignored while busy. SEQ_ALU_SLT_EN enables signed set-less-than on op 111.
module seq_alu_datapath
    import seq_alu_pkg::*;
#(
    parameter int N    = 8,
    parameter int NREG = 8
) (
    input  logic        clk,
    input  logic        rst,
    seq_alu_if.slave    bus
);

    localparam int AW = $clog2(NREG);

    state_t        state_q, state_d;
    logic [2:0]    op_q, op_d;
    logic [AW-1:0] ra1_q, ra1_d;
    logic [AW-1:0] ra2_q, ra2_d;
    logic [AW-1:0] wa3_q, wa3_d;
    logic          use_imm_q, use_imm_d;
    logic [N-1:0]  imm_q, imm_d;
    logic [N-1:0]  a_q, a_d;
    logic [N-1:0]  b_q, b_d;
    logic [N-1:0]  result_q, result_d;
    logic          zero_q, zero_d;
    logic          out_valid_q, out_valid_d;

    logic [N-1:0]  rd1, rd2;
    logic [N-1:0]  alu_res;
    logic          wr_en;

    regfile_zr #(.N(N), .NREG(NREG), .AW(AW)) u_rf (
        .clk      (clk),
        .rst      (rst),
        .we       (wr_en),
        .wa       (wa3_q),
        .wd       (result_q),
        .ra1      (ra1_q),
        .rd1      (rd1),
        .ra2      (ra2_q),
        .rd2      (rd2),
        .dbg_addr (bus.dbg_addr),
        .dbg_data (bus.dbg_data)
    );

    always_comb begin
        alu_res = '0;
        case (op_q)
            OP_AND: alu_res = a_q & b_q;
            OP_OR:  alu_res = a_q | b_q;
            OP_ADD: alu_res = a_q + b_q;
            OP_SUB: alu_res = a_q - b_q;
`ifdef SEQ_ALU_SLT_EN
            OP_SLT: alu_res = {{(N-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
`else
            OP_SLT: alu_res = '0;
`endif
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        ra1_d       = ra1_q;
        ra2_d       = ra2_q;
        wa3_d       = wa3_q;
        use_imm_d   = use_imm_q;
        imm_d       = imm_q;
        a_d         = a_q;
        b_d         = b_q;
        result_d    = result_q;
        zero_d      = zero_q;
        out_valid_d = (state_q == S_WB);
        wr_en       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    op_d      = bus.op;
                    ra1_d     = bus.ra1;
                    ra2_d     = bus.ra2;
                    wa3_d     = bus.wa3;
                    use_imm_d = bus.use_imm;
                    imm_d     = bus.imm;
                    state_d   = S_READ;
                end
            end
            S_READ: begin
                a_d     = rd1;
                b_d     = use_imm_q ? imm_q : rd2;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                result_d = alu_res;
                zero_d   = (alu_res == '0);
                state_d  = S_WB;
            end
            S_WB: begin
                wr_en   = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            op_q        <= '0;
            ra1_q       <= '0;
            ra2_q       <= '0;
            wa3_q       <= '0;
            use_imm_q   <= 1'b0;
            imm_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            result_q    <= '0;
            zero_q      <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            ra1_q       <= ra1_d;
            ra2_q       <= ra2_d;
            wa3_q       <= wa3_d;
            use_imm_q   <= use_imm_d;
            imm_q       <= imm_d;
            a_q         <= a_d;
            b_q         <= b_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.zero      = zero_q;

endmodule

// File: tb/tb_seq_alu_datapath.sv
// Directed vector table plus hand-written busy/abort/reset sequences for seq_alu_datapath (N=8, NREG=8).
module tb_seq_alu_datapath;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    seq_alu_if #(.N(8), .NREG(8)) bus ();

    seq_alu_datapath #(.N(8), .NREG(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [2:0] op;
        logic [2:0] ra1;
        logic [2:0] ra2;
        logic [2:0] wa3;
        logic       use_imm;
        logic [7:0] imm;
        logic [7:0] exp_res;
        logic       exp_zero;
        logic [7:0] exp_wr;
    } vec_t;

`ifdef SEQ_ALU_SLT_EN
    localparam logic [7:0] SLT_TRUE = 8'h01;
    localparam logic       SLT_TRUE_Z = 1'b0;
`else
    localparam logic [7:0] SLT_TRUE = 8'h00;
    localparam logic       SLT_TRUE_Z = 1'b1;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic drive(input vec_t v);
        bus.op      = v.op;
        bus.ra1     = v.ra1;
        bus.ra2     = v.ra2;
        bus.wa3     = v.wa3;
        bus.use_imm = v.use_imm;
        bus.imm     = v.imm;
    endtask

    // Presents v until accepted, then returns #1 after the edge where out_valid is first seen.
    task automatic issue(input vec_t v, output int lat);
        int k;
        k = 0;
        drive(v);
        bus.in_valid = 1'b1;
        while (!bus.in_ready && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        if (k == 20) check("in_ready_timeout", 0, 1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    vec_t vecs[15];

    initial begin
        int   lat;
        int   pulses;
        vec_t v;

        vecs[0]  = '{3'b010, 3'd0, 3'd0, 3'd3, 1'b1, 8'h07, 8'h07, 1'b0, 8'h07};
        vecs[1]  = '{3'b010, 3'd3, 3'd3, 3'd4, 1'b0, 8'h00, 8'h0E, 1'b0, 8'h0E};
        vecs[2]  = '{3'b010, 3'd0, 3'd0, 3'd1, 1'b1, 8'hFF, 8'hFF, 1'b0, 8'hFF};
        vecs[3]  = '{3'b010, 3'd1, 3'd0, 3'd5, 1'b1, 8'h01, 8'h00, 1'b1, 8'h00};
        vecs[4]  = '{3'b110, 3'd3, 3'd3, 3'd6, 1'b0, 8'h00, 8'h00, 1'b1, 8'h00};
        vecs[5]  = '{3'b010, 3'd0, 3'd0, 3'd0, 1'b1, 8'h55, 8'h55, 1'b0, 8'h00};
        vecs[6]  = '{3'b000, 3'd1, 3'd4, 3'd2, 1'b0, 8'h00, 8'h0E, 1'b0, 8'h0E};
        vecs[7]  = '{3'b001, 3'd3, 3'd0, 3'd6, 1'b1, 8'hF0, 8'hF7, 1'b0, 8'hF7};
        vecs[8]  = '{3'b110, 3'd3, 3'd4, 3'd7, 1'b0, 8'h00, 8'hF9, 1'b0, 8'hF9};
        vecs[9]  = '{3'b010, 3'd0, 3'd0, 3'd1, 1'b1, 8'h80, 8'h80, 1'b0, 8'h80};
        vecs[10] = '{3'b010, 3'd0, 3'd0, 3'd2, 1'b1, 8'h01, 8'h01, 1'b0, 8'h01};
        vecs[11] = '{3'b111, 3'd1, 3'd2, 3'd5, 1'b0, 8'h00, SLT_TRUE, SLT_TRUE_Z, SLT_TRUE};
        vecs[12] = '{3'b111, 3'd2, 3'd1, 3'd6, 1'b0, 8'h00, 8'h00, 1'b1, 8'h00};
        vecs[13] = '{3'b011, 3'd4, 3'd0, 3'd7, 1'b1, 8'h12, 8'h00, 1'b1, 8'h00};
        vecs[14] = '{3'b100, 3'd1, 3'd2, 3'd0, 1'b0, 8'h00, 8'h00, 1'b1, 8'h00};

        bus.in_valid = 1'b0;
        bus.op       = '0;
        bus.ra1      = '0;
        bus.ra2      = '0;
        bus.wa3      = '0;
        bus.use_imm  = 1'b0;
        bus.imm      = '0;
        bus.dbg_addr = '0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_busy", bus.busy, 0);
        check("rst_result", bus.result, 8'h00);
        check("rst_zero", bus.zero, 1);
        check("rst_out_valid", bus.out_valid, 0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 15; i++) begin
            issue(vecs[i], lat);
            check($sformatf("v%0d_latency", i), lat, 3);
            check($sformatf("v%0d_result", i), bus.result, vecs[i].exp_res);
            check($sformatf("v%0d_zero", i), bus.zero, vecs[i].exp_zero);
            check($sformatf("v%0d_in_ready", i), bus.in_ready, 1);
            bus.dbg_addr = vecs[i].wa3;
            #1;
            check($sformatf("v%0d_dbg", i), bus.dbg_data, vecs[i].exp_wr);
        end

        // result/zero hold while idle
        repeat (3) @(posedge clk);
        #1;
        check("hold_result", bus.result, 8'h00);
        check("hold_out_valid", bus.out_valid, 0);

        // mid-run async reset clears everything while asserted
        #2 rst = 1'b0;
        #1;
        check("mrst_in_ready", bus.in_ready, 1);
        check("mrst_busy", bus.busy, 0);
        check("mrst_result", bus.result, 8'h00);
        check("mrst_zero", bus.zero, 1);
        for (int a = 0; a < 8; a++) begin
            bus.dbg_addr = 3'(a);
            #0.1;
            check($sformatf("mrst_dbg%0d", a), bus.dbg_data, 8'h00);
        end
        @(negedge clk);
        rst = 1'b1;

        // in_valid held high with changing fields while busy: only the first instruction runs
        @(negedge clk);
        v = '{3'b010, 3'd0, 3'd0, 3'd2, 1'b1, 8'h11, 8'h11, 1'b0, 8'h11};
        drive(v);
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        check("busy_t0", bus.busy, 1);
        bus.op = 3'b110; bus.imm = 8'h22; bus.wa3 = 3'd3;
        @(posedge clk); #1;
        check("busy_t1", bus.busy, 1);
        bus.op = 3'b001; bus.imm = 8'h44; bus.wa3 = 3'd5;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("busy_out_valid", bus.out_valid, 1);
        check("busy_result", bus.result, 8'h11);
        bus.in_valid = 1'b0;
        pulses = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            if (bus.out_valid) pulses++;
        end
        check("busy_extra_pulses", pulses, 0);
        bus.dbg_addr = 3'd2; #1;
        check("busy_dbg2", bus.dbg_data, 8'h11);
        bus.dbg_addr = 3'd3; #1;
        check("busy_dbg3", bus.dbg_data, 8'h00);
        bus.dbg_addr = 3'd5; #1;
        check("busy_dbg5", bus.dbg_data, 8'h00);

        // reset pulsed during EXEC aborts with no writeback
        @(negedge clk);
        v = '{3'b010, 3'd0, 3'd0, 3'd4, 1'b1, 8'h33, 8'h33, 1'b0, 8'h33};
        drive(v);
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk); #2;
        rst = 1'b0;
        #1;
        check("abort_busy", bus.busy, 0);
        @(negedge clk);
        rst = 1'b1;
        pulses = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            if (bus.out_valid) pulses++;
        end
        check("abort_pulses", pulses, 0);
        check("abort_result", bus.result, 8'h00);
        check("abort_zero", bus.zero, 1);
        bus.dbg_addr = 3'd4; #1;
        check("abort_dbg4", bus.dbg_data, 8'h00);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
